// File: rtl/systolic_controller_if.sv
// systolic_controller_if: operand stream, strobes and status between a tile sequencer and its host
interface systolic_controller_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int MATRIX_SIZE = 8,
  parameter int LEN_WIDTH   = 16
);
  logic                              start;
  logic                              abort;
  logic [LEN_WIDTH-1:0]              k_len;
  logic                              in_valid;
  logic                              in_ready;
  logic [DATA_WIDTH*MATRIX_SIZE-1:0] in_top_flat;
  logic [DATA_WIDTH*MATRIX_SIZE-1:0] in_left_flat;
  logic [DATA_WIDTH*MATRIX_SIZE-1:0] data_out_top;
  logic [DATA_WIDTH*MATRIX_SIZE-1:0] data_out_left;
  logic                              load_en_top;
  logic                              load_en_left;
  logic                              swap_buffers_top;
  logic                              swap_buffers_left;
  logic                              shift_en;
  logic                              acc_en;
  logic                              acc_rst;
  logic                              busy;
  logic                              done;
  modport master (
    output start, abort, k_len, in_valid, in_top_flat, in_left_flat,
    input  in_ready, data_out_top, data_out_left, load_en_top, load_en_left,
           swap_buffers_top, swap_buffers_left, shift_en, acc_en, acc_rst, busy, done
  );
  modport slave (
    input  start, abort, k_len, in_valid, in_top_flat, in_left_flat,
    output in_ready, data_out_top, data_out_left, load_en_top, load_en_left,
           swap_buffers_top, swap_buffers_left, shift_en, acc_en, acc_rst, busy, done
  );
endinterface

// File: rtl/systolic_controller.sv
// systolic_controller: sequences clear, operand feed, zero drain and completion for one systolic tile
module systolic_controller #(
  parameter int DATA_WIDTH  = 8,
  parameter int MATRIX_SIZE = 8,
  parameter int LEN_WIDTH   = 16
) (
  input logic                clk,
  input logic                rst,
  systolic_controller_if.slave bus
);
  localparam int W         = DATA_WIDTH * MATRIX_SIZE;
  localparam int DRAIN_CYC = 2 * MATRIX_SIZE - 2;
  localparam int CW        = $clog2(DRAIN_CYC + 2);
  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FEED, S_DRAIN, S_FLUSH, S_DONE} state_t;
  state_t               r_state, w_next;
  logic [LEN_WIDTH-1:0] r_k_rem;
  logic [CW-1:0]        r_drain_cnt;
  logic                 r_shift;
  logic                 w_hs, w_load, w_abort, w_accept;
  assign w_hs     = r_state == S_FEED && bus.in_valid;
  assign w_load   = w_hs || r_state == S_DRAIN;
  assign w_abort  = bus.abort && r_state != S_IDLE;
  assign w_accept = r_state == S_IDLE && bus.start && !bus.abort;
  assign bus.in_ready          = r_state == S_FEED;
  assign bus.acc_rst           = r_state == S_CLEAR;
  assign bus.done              = r_state == S_DONE;
  assign bus.busy              = r_state != S_IDLE;
  assign bus.load_en_top       = w_load;
  assign bus.load_en_left      = w_load;
  assign bus.swap_buffers_top  = w_load;
  assign bus.swap_buffers_left = w_load;
  assign bus.data_out_top      = w_hs ? bus.in_top_flat : {W{1'b0}};
  assign bus.data_out_left     = w_hs ? bus.in_left_flat : {W{1'b0}};
  assign bus.shift_en          = r_shift;
  assign bus.acc_en            = r_shift;
  // next-state selection; abort overrides every non-idle transition
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_CLEAR;
      S_CLEAR: w_next = r_k_rem != '0 ? S_FEED : S_DONE;
      S_FEED:  if (w_hs && r_k_rem == LEN_WIDTH'(1)) w_next = DRAIN_CYC == 0 ? S_FLUSH : S_DRAIN;
      S_DRAIN: if (r_drain_cnt == CW'(DRAIN_CYC - 1)) w_next = S_FLUSH;
      S_FLUSH: w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (w_abort) w_next = S_IDLE;
  end
  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end
  // remaining-vector count, drain length and the one-cycle-delayed shift/accumulate strobe
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_k_rem     <= '0;
      r_drain_cnt <= '0;
      r_shift     <= 1'b0;
    end else begin
      r_k_rem     <= w_accept ? bus.k_len : w_hs ? r_k_rem - 1'b1 : r_k_rem;
      r_drain_cnt <= (r_state == S_DRAIN && !w_abort) ? r_drain_cnt + 1'b1 : '0;
      r_shift     <= w_load && !w_abort;
    end
  end
endmodule

// File: doc/systolic_controller.md
# systolic_controller

Sequencing controller for the buffered systolic module. Runs one output-stationary tile computation per `start`:
- clears the accumulators;
- accepts K paired top/left operand vectors through a valid/ready stream and writes each into both double buffers;
- issues the matching swap, shift and accumulate strobes;
- feeds 2·(MATRIX_SIZE−1) zero vectors to drain the array;
- pulses `done` once `acc_out_flat` of the module holds the final tile.

Upstream is responsible for operand skew. This block only moves vectors and strobes.

## Interface
- `DATA_WIDTH`, 8, operand element width
- `MATRIX_SIZE`, 8, array dimension N
- `LEN_WIDTH`, 16, width of the vector-count field K
- `clk` input 1 — the single clock for the block
- `rst` input 1 — asynchronous, active-low reset
- `start` input 1 — begin a tile; sampled only in IDLE
- `abort` input 1 — synchronous cancel; wins over `start`
- `k_len` input LEN_WIDTH — number of operand vectors K; sampled with `start`
- `in_valid` input 1 — paired operand vectors present
- `in_ready` output 1 — controller accepts a vector this cycle
- `in_top_flat`, `in_left_flat` input DATA_WIDTH*MATRIX_SIZE — operand vectors
- `data_out_top`, `data_out_left` output DATA_WIDTH*MATRIX_SIZE — drive the module's `data_in_flat_top` and `data_in_flat_left`
- `load_en_top`, `load_en_left` output 1 — buffer write strobes
- `swap_buffers_top`, `swap_buffers_left` output 1 — buffer swap strobes
- `shift_en`, `acc_en`, `acc_rst` output 1 — array control
- `busy` output 1 — high in every state except IDLE
- `done` output 1 — one-cycle completion pulse

## Operation
States and transitions:
- IDLE → CLEAR on `start` && !`abort`. `k_len` is latched into `k_rem`.
- CLEAR (1 cycle):
  - `acc_rst`=1.
  - Goes to FEED if `k_rem`≠0, else to DONE.
- FEED:
  - `in_ready`=1.
  - Handshake = `in_valid` && `in_ready`. On a handshake, `load_en_*`=`swap_buffers_*`=1 and `data_out_*`=`in_*_flat`, all in the same cycle; `k_rem` decrements.
  - On the handshake that takes `k_rem` from 1 to 0, go to DRAIN.
  - `in_valid`=0 is a stall: no strobes, and the array is frozen.
- DRAIN (exactly 2N−2 cycles, counted by `drain_cnt`):
  - `load_en_*`=`swap_buffers_*`=1 and `data_out_*`=0 every cycle.
  - `in_ready`=0.
  - Then go to FLUSH.
- FLUSH (1 cycle): no load or swap. It exists only so the final pipelined shift can issue. Then go to DONE.
- DONE (1 cycle): `done`=1, then go to IDLE.

Output rules:
- `shift_en` and `acc_en` are both a register of "load issued last cycle". Each loaded vector (operand or zero) therefore produces exactly one shift/accumulate, one cycle after its load/swap.
- `load_en_*`, `swap_buffers_*`, `data_out_*`, `in_ready`, `acc_rst`, `done` and `busy` are combinational from the state (plus `in_valid` in FEED).
- `data_out_*` is 0 whenever no load is issued.
- Top and left strobes are always identical.
- `abort` in any non-IDLE state:
  - The next state is IDLE.
  - The pending `shift_en`/`acc_en` is cleared.
  - No `done` is issued.
  - Accumulator contents are undefined afterwards.
- `start` outside IDLE is ignored.
- The controller never touches the accumulators outside CLEAR, so results stay valid until the next `start`.

## Timing
- Reset: state IDLE; `k_rem`=0, `drain_cnt`=0. All outputs are 0 (`busy`, `done`, `in_ready`, every strobe, `data_out_*`).
- Latency with no stalls, `start` at cycle 0:
  - CLEAR at 1.
  - FEED at 2..K+1.
  - DRAIN at K+2..K+2N−1.
  - FLUSH at K+2N.
  - `done` at K+2N+1.
  - The last `shift_en` is at K+2N.
- Each stall cycle in FEED adds exactly one cycle to the `done` time.
- K=0: `done` at cycle 2, no load or shift is issued, and the accumulators read 0.
- Throughput is one vector per cycle. `in_ready` is asserted continuously through FEED, including the cycle of the final handshake.
- `busy` falls in the cycle after `done`. A `start` is accepted in that same cycle, which is the IDLE cycle; back-to-back tiles therefore have one idle cycle between them.
- `k_len` is an unsigned count with no wrap. The maximum is 2^LEN_WIDTH−1.

## Test plan
- Reset, then N=8, K=8, `in_valid` held high. Required:
  - `acc_rst` at cycle 1.
  - Handshakes at cycles 2–9 with `load_en`=`swap`=1.
  - Zero loads at cycles 10–23.
  - `shift_en` at cycles 3–24, 22 pulses in total.
  - `done` at cycle 25.
  - With identity vectors, `acc_out` equals the expected 8×8 product.
- Same run with `in_valid` low at cycles 4–6. Required: no strobes at cycles 4–6 and no `shift_en` at cycles 5–7; `done` at cycle 28; results identical to the unstalled run.
- K=0. Required: `acc_rst` at cycle 1 and `done` at cycle 2; no load, swap or shift at any time.
- `abort` asserted during DRAIN. Required: IDLE next cycle; every strobe 0 from that cycle; no `done`. A new `start` afterwards completes normally.
- `start` while busy, and `start`+`abort` in IDLE. Required: both ignored; `busy` stays at its prior value.
- `rst` asserted low asynchronously mid-FEED. Required: all outputs 0 immediately, and the state is IDLE after release.
